// File: rtl/mul_div_sequencer.sv
// Iterative 32-bit MUL/MULHU/DIVU/REMU sequencer around one shared ALU; accept in cycle T gives out_valid in cycle T+33.
// One operation in flight; the result is held in DONE until out_ready, and kill aborts from any busy state.

module alu (
  input  logic [3:0]  alufn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        cf
);
  logic [32:0] wide;

  always_comb begin
    wide = 33'd0;
    y    = 32'd0;
    cf   = 1'b0;
    case (alufn)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[31:0];
        cf   = wide[32];
      end
      4'b0001: begin
        // cf = 1 means no borrow, i.e. a >= b unsigned
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[31:0];
        cf   = ~wide[32];
      end
      default: begin
        y  = 32'd0;
        cf = 1'b0;
      end
    endcase
  end
endmodule

module mul_div_sequencer #(
  parameter int n = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [n-1:0]  rs1,
  input  logic [n-1:0]  rs2,
  input  logic          kill,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  result,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] rs2_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;

  logic        is_div;
  logic [3:0]  alufn;
  logic [31:0] alu_a;
  logic [31:0] alu_y;
  logic        alu_cf;
  logic        carry;
  logic [31:0] sum_hi;
  logic        take;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic [31:0] res_nxt;

  assign is_div   = op_q[1];
  assign alufn    = is_div ? 4'b0001 : 4'b0000;
  // divide trial subtracts from the left-shifted remainder; multiply adds into hi
  assign alu_a    = is_div ? {hi[30:0], lo[31]} : hi;
  assign in_ready = (state == IDLE) && !kill;
  assign busy     = (state != IDLE);

  alu u_alu (
    .alufn (alufn),
    .a     (alu_a),
    .b     (rs2_q),
    .y     (alu_y),
    .cf    (alu_cf)
  );

  always_comb begin
    carry  = 1'b0;
    sum_hi = hi;
    take   = 1'b0;
    hi_nxt = hi;
    lo_nxt = lo;
    if (!is_div) begin
      carry  = lo[0] ? alu_cf : 1'b0;
      sum_hi = lo[0] ? alu_y : hi;
      hi_nxt = {carry, sum_hi[31:1]};
      lo_nxt = {sum_hi[0], lo[31:1]};
    end else begin
      // hi[31] is the bit shifted out; if set, the 33-bit remainder exceeds rs2
      take   = hi[31] | alu_cf;
      hi_nxt = take ? alu_y : {hi[30:0], lo[31]};
      lo_nxt = {lo[30:0], take};
    end
    // MUL and DIVU read lo (product low / quotient); MULHU and REMU read hi
    res_nxt = op_q[0] ? hi_nxt : lo_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'd0;
      rs2_q     <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q  <= op;
            rs2_q <= rs2;
            hi    <= 32'd0;
            lo    <= rs1;
            cnt   <= 5'd0;
            state <= RUN;
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= res_nxt;
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: directed vectors, expected results queued at issue and checked at handshake.

module tb_mul_div_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  localparam logic [1:0] MUL = 2'b00, MULHU = 2'b01, DIVU = 2'b10, REMU = 2'b11;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int cyc = 0;
  int acc_cyc = 0;
  bit ov_prev = 1'b0;

  mul_div_sequencer #(.n(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // monitor: latency on each rising out_valid, result compare on each handshake
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !ov_prev) begin
        checks++;
        if (cyc - acc_cyc != 33) begin
          errors++;
          $display("FAIL latency: got %0d cycles, want 33", cyc - acc_cyc);
        end
      end
      if (out_valid && out_ready && !kill) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got 0x%08h with no result expected", result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            errors++;
            $display("FAIL result: got 0x%08h, want 0x%08h", result, e);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
    end
  endtask

  // returns one tick after the accepting edge (state RUN, step 0)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit push);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    if (push) exp_q.push_back(e);
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output bit ok, output bit busy_ok);
    ok = 1'b0;
    busy_ok = 1'b1;
    for (int t = 0; t < 80 && !ok; t++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    bit ok, bo;
    out_ready = 1'b1;
    issue(o, a, b, e, 1'b1);
    wait_out(ok, bo);
    chk("out_valid_seen", {31'd0, ok}, 32'd1);
    chk("busy_while_running", {31'd0, bo}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok, bo, seen;

    // reset with a request presented: must not be accepted
    rst = 1'b1; in_valid = 1'b1; op = MUL; rs1 = 32'd5; rs2 = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_no_accept", {31'd0, busy}, 32'd0);

    run_op(MUL,   32'd7,        32'd6,        32'h0000002A);
    run_op(MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(MULHU, 32'h80000000, 32'd4,        32'h00000002);
    run_op(DIVU,  32'd100,      32'd7,        32'd14);
    run_op(REMU,  32'd100,      32'd7,        32'd2);
    run_op(DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h00000001);
    run_op(REMU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE);
    run_op(DIVU,  32'h1234,     32'd0,        32'hFFFFFFFF);
    run_op(REMU,  32'h1234,     32'd0,        32'h00001234);

    // backpressure: 5 held cycles with a new request waiting
    out_ready = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_out(ok, bo);
    chk("bp_out_valid_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; op = REMU; rs1 = 32'd100; rs2 = 32'd7;
    exp_q.push_back(32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result_hold", result, 32'd14);
      chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_handshake_cycle", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_next_cycle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", {31'd0, busy}, 32'd1);
    wait_out(ok, bo);
    chk("bp_second_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;

    // kill in IDLE blocks acceptance
    @(posedge clk); #1;
    in_valid = 1'b1; kill = 1'b1; op = MUL; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    chk("kill_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_idle_not_busy", {31'd0, busy}, 32'd0);

    // kill at RUN step 10
    issue(MUL, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_run_busy", {31'd0, busy}, 32'd0);
    chk("kill_run_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("kill_run_no_out_valid", {31'd0, seen}, 32'd0);

    // kill together with out_ready in DONE: no handshake
    out_ready = 1'b0;
    issue(MUL, 32'd4, 32'd4, 32'd0, 1'b0);
    wait_out(ok, bo);
    chk("kill_done_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_done_busy", {31'd0, busy}, 32'd0);

    // reset at RUN step 20, with a request presented during reset
    issue(MUL, 32'h12345678, 32'd9, 32'd0, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1; in_valid = 1'b1; op = MUL; rs1 = 32'd7; rs2 = 32'd7;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_no_accept", {31'd0, busy}, 32'd0);
    run_op(MUL, 32'd3, 32'd5, 32'd15);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter: n, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  2  00 MUL (low 32), 01 MULHU, 10 DIVU, 11 REMU.
REQ-007 rs1  input  32  multiplicand / dividend.
REQ-008 rs2  input  32  multiplier / divisor.
REQ-009 kill  input  1  abort the in-flight operation (pipeline flush).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  32  registered result.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL sequence a single instance of the team ALU, using alufn 4'b0000 (add) for multiply steps and 4'b0001 (subtract) for divide steps; ALU cf on subtract = 1 means no borrow (unsigned a >= b).
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; in_ready = (state == IDLE) && !kill.
REQ-016 Accept occurs when in_valid && in_ready; on accept op, rs1, rs2 are latched, a 5-bit step counter is cleared, and state goes IDLE->RUN.
REQ-017 RUN SHALL last exactly 32 cycles (counter 0..31); after step 31, state goes RUN->DONE with out_valid = 1.
REQ-018 Latency: accept in cycle T -> out_valid first high in cycle T+33.
REQ-019 MUL/MULHU: 65-bit {carry, hi, lo} with hi = 0, lo = rs1 at accept; each step, if lo[0], hi = hi + rs2 (carry = ALU cf), else carry = 0; then {carry, hi, lo} shifts right 1. The result SHALL be lo for MUL and hi for MULHU.
REQ-020 DIVU/REMU: R = 0, Q = rs1 at accept; each step, {msb, R, Q} = {R, Q} << 1; trial = R - rs2 via ALU; if (msb | cf) then R = trial and Q[0] = 1. The result SHALL be Q for DIVU and R for REMU.
REQ-021 Divide by zero SHALL use the same 32-cycle path with no special casing: DIVU -> 0xFFFFFFFF, REMU -> rs1.
REQ-022 DONE SHALL hold result and out_valid stable until out_ready; on out_valid && out_ready, state goes DONE->IDLE and out_valid drops the next cycle.
REQ-023 There is no overlap: a new request is accepted only in IDLE, at the earliest one cycle after the result handshake.
REQ-024 kill in RUN or DONE SHALL move the FSM to IDLE next cycle with out_valid = 0; no result is delivered.
REQ-025 kill in IDLE SHALL block acceptance in that cycle, even if in_valid = 1.
REQ-026 kill together with out_ready in DONE SHALL be treated as kill: no handshake is counted.
REQ-027 The result register SHALL update only on the RUN->DONE transition.

Reset
REQ-028 rst SHALL have priority over kill and all handshakes, from any state including mid-RUN.
REQ-029 After rst: state = IDLE, out_valid = 0, busy = 0, result = 0, counter = 0, internal hi/lo/R/Q = 0; in_ready = 1 from the first cycle after rst deasserts.
REQ-030 A request presented during rst SHALL NOT be accepted.

Verification
REQ-031 MUL 7 x 6 -> result 0x0000002A; out_valid exactly 33 cycles after accept; busy high throughout.
REQ-032 rs1 = rs2 = 0xFFFFFFFF -> MUL = 0x00000001, MULHU = 0xFFFFFFFE.
REQ-033 DIVU/REMU 100 / 7 -> 14 / 2; 0xFFFFFFFF / 0x80000001 -> 1 / 0x7FFFFFFE (exercises msb path).
REQ-034 DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x00001234.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles in DONE, with in_valid = 1 -> result stable, in_ready = 0; accept occurs one cycle after out_ready.
REQ-036 kill at RUN step 10 -> IDLE next cycle, no out_valid; rst at step 20 -> all REQ-029 values; a following MUL 3 x 5 -> 15.
